// File: rtl/psg_attr_ram_pkg.sv
// Shared PSG audio types: attribute-store FSM states and the legality rules
// for its size parameters.
package psg_attr_ram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SCAN  = 2'd2
  } attr_state_e;

  function automatic bit num_ch_legal(int num_ch);
    return (num_ch >= 32'sd2) && (num_ch <= 32'sd64);
  endfunction

  function automatic bit bytes_per_ch_legal(int bytes);
    return (bytes >= 32'sd1) && (bytes <= 32'sd8) &&
           ((bytes & (bytes - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/psg_attr_ram_mem.sv
// Channel attribute array: byte-lane write, registered read-before-write.
// Deliberately reset-free so it maps onto block RAM.
module psg_attr_mem
  import psg_attr_ram_pkg::*;
#(
  parameter int NUM_CH       = 16,
  parameter int BYTES_PER_CH = 4,
  parameter int CH_W         = $clog2(NUM_CH),
  parameter int DATA_W       = 8 * BYTES_PER_CH
) (
  input  logic                    clk,
  input  logic [BYTES_PER_CH-1:0] we,
  input  logic [CH_W-1:0]         waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    re,
  input  logic [CH_W-1:0]         raddr,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem_r [NUM_CH];
  logic [DATA_W-1:0] rdata_r;

  // Byte-lane writes and the registered read port
  always_ff @(posedge clk) begin
    for (int b = 0; b < BYTES_PER_CH; b++) begin
      if (we[b]) begin
        mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/psg_attr_ram.sv
// PSG per-channel attribute store: CPU byte writes, random word reads, a
// sequencer-triggered channel scan, and a self-clearing sequence.
module psg_attr_ram
  import psg_attr_ram_pkg::*;
#(
  parameter  int NUM_CH       = 16,
  parameter  int BYTES_PER_CH = 4,
  localparam int CH_W         = $clog2(NUM_CH),
  localparam int LANE_W       = $clog2(BYTES_PER_CH),
  localparam int ADDR_W       = CH_W + LANE_W,
  localparam int DATA_W       = 8 * BYTES_PER_CH
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic              rd_en_i,
  input  logic [CH_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              scan_start_i,
  output logic              scan_valid_o,
  output logic [CH_W-1:0]   scan_ch_o,
  output logic [DATA_W-1:0] scan_data_o,
  output logic              scan_last_o,
  output logic              busy_o
);

  if (!num_ch_legal(NUM_CH) || !bytes_per_ch_legal(BYTES_PER_CH)) begin : g_param_chk
    $error("psg_attr_ram: NUM_CH must be 2..64, BYTES_PER_CH a power of two 1..8");
  end

  localparam int              LANE_SEL_W = (LANE_W > 0) ? LANE_W : 1;
  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NUM_CH_X   = (CH_W + 1)'(NUM_CH);

  attr_state_e state_r, state_nxt_s;
  logic [CH_W-1:0]         clr_cnt_r, clr_cnt_nxt_s;
  logic [CH_W-1:0]         scan_cnt_r, scan_cnt_nxt_s;

  logic [CH_W-1:0]         wr_ch_s;
  logic [LANE_SEL_W-1:0]   wr_lane_s;
  logic [BYTES_PER_CH-1:0] wr_be_s;
  logic                    wr_ch_ok_s;
  logic                    rd_ch_ok_s;

  logic [BYTES_PER_CH-1:0] mem_we_s;
  logic [CH_W-1:0]         mem_waddr_s;
  logic [DATA_W-1:0]       mem_wdata_s;
  logic                    mem_re_s;
  logic [CH_W-1:0]         mem_raddr_s;
  logic [DATA_W-1:0]       mem_rdata_s;
  logic                    rd_win_s;
  logic                    scan_issue_s;
  logic                    scan_keep_s;

  logic                    rd_valid_r;
  logic                    rd_oor_r;
  logic [DATA_W-1:0]       rd_hold_r;
  logic [DATA_W-1:0]       rd_data_s;
  logic                    scan_valid_r;
  logic                    scan_last_r;
  logic [CH_W-1:0]         scan_ch_r;

  assign wr_ch_s = wr_addr_i[ADDR_W-1:LANE_W];
  if (LANE_W > 0) begin : g_lane
    assign wr_lane_s = wr_addr_i[LANE_SEL_W-1:0];
  end else begin : g_no_lane
    assign wr_lane_s = 1'b0;
  end

  assign wr_be_s    = BYTES_PER_CH'(1'b1) << wr_lane_s;
  assign wr_ch_ok_s = ({1'b0, wr_ch_s} < NUM_CH_X);
  assign rd_ch_ok_s = ({1'b0, rd_addr_i} < NUM_CH_X);

  // FSM state and counters
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r    <= ST_CLEAR;
      clr_cnt_r  <= {CH_W{1'b0}};
      scan_cnt_r <= {CH_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      clr_cnt_r  <= clr_cnt_nxt_s;
      scan_cnt_r <= scan_cnt_nxt_s;
    end
  end

  // Next-state logic; clear_i overrides every state
  always_comb begin
    state_nxt_s    = state_r;
    clr_cnt_nxt_s  = clr_cnt_r;
    scan_cnt_nxt_s = scan_cnt_r;
    if (clear_i) begin
      state_nxt_s   = ST_CLEAR;
      clr_cnt_nxt_s = {CH_W{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == LAST_CH) begin
            state_nxt_s = ST_IDLE;
          end else begin
            clr_cnt_nxt_s = clr_cnt_r + CH_W'(1);
          end
        end
        ST_IDLE: begin
          if (scan_start_i) begin
            state_nxt_s    = ST_SCAN;
            scan_cnt_nxt_s = {CH_W{1'b0}};
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (scan_issue_s && (scan_cnt_r == LAST_CH)) begin
            state_nxt_s = ST_IDLE;
          end else if (scan_issue_s) begin
            scan_cnt_nxt_s = scan_cnt_r + CH_W'(1);
          end else begin
            state_nxt_s = ST_SCAN;
          end
        end
        default: begin
          state_nxt_s   = ST_CLEAR;
          clr_cnt_nxt_s = {CH_W{1'b0}};
        end
      endcase
    end
  end

  // Memory port control: clear writes, CPU writes, read arbitration
  always_comb begin
    mem_we_s     = {BYTES_PER_CH{1'b0}};
    mem_waddr_s  = wr_ch_s;
    mem_wdata_s  = {BYTES_PER_CH{wr_data_i}};
    mem_re_s     = 1'b0;
    mem_raddr_s  = scan_cnt_r;
    rd_win_s     = 1'b0;
    scan_issue_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s    = {BYTES_PER_CH{1'b1}};
        mem_waddr_s = clr_cnt_r;
        mem_wdata_s = {DATA_W{1'b0}};
      end
      ST_IDLE, ST_SCAN: begin
        if (wr_en_i && wr_ch_ok_s) begin
          mem_we_s = wr_be_s;
        end else begin
          mem_we_s = {BYTES_PER_CH{1'b0}};
        end
        // Random reads win the port; the scan stalls for that cycle
        if (rd_en_i) begin
          rd_win_s    = 1'b1;
          mem_re_s    = rd_ch_ok_s;
          mem_raddr_s = rd_addr_i;
        end else if (state_r == ST_SCAN) begin
          scan_issue_s = 1'b1;
          mem_re_s     = 1'b1;
        end else begin
          mem_re_s = 1'b0;
        end
      end
      default: begin
        mem_we_s = {BYTES_PER_CH{1'b0}};
      end
    endcase
  end

  assign scan_keep_s = scan_issue_s && !clear_i;

  // Output flags, scan channel tag and held random-read data
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rd_valid_r   <= 1'b0;
      rd_oor_r     <= 1'b0;
      rd_hold_r    <= {DATA_W{1'b0}};
      scan_valid_r <= 1'b0;
      scan_last_r  <= 1'b0;
      scan_ch_r    <= {CH_W{1'b0}};
    end else begin
      rd_valid_r   <= rd_win_s;
      scan_valid_r <= scan_keep_s;
      scan_last_r  <= scan_keep_s && (scan_cnt_r == LAST_CH);
      if (rd_win_s) begin
        rd_oor_r <= !rd_ch_ok_s;
      end
      if (rd_valid_r) begin
        rd_hold_r <= rd_data_s;
      end
      if (scan_keep_s) begin
        scan_ch_r <= scan_cnt_r;
      end
    end
  end

  psg_attr_mem #(
    .NUM_CH      (NUM_CH),
    .BYTES_PER_CH(BYTES_PER_CH),
    .CH_W        (CH_W),
    .DATA_W      (DATA_W)
  ) u_mem (
    .clk  (clk_i),
    .we   (mem_we_s),
    .waddr(mem_waddr_s),
    .wdata(mem_wdata_s),
    .re   (mem_re_s),
    .raddr(mem_raddr_s),
    .rdata(mem_rdata_s)
  );

  assign rd_data_s    = rd_oor_r ? {DATA_W{1'b0}} : mem_rdata_s;
  assign rd_data_o    = rd_valid_r ? rd_data_s : rd_hold_r;
  assign rd_valid_o   = rd_valid_r;
  assign scan_valid_o = scan_valid_r;
  assign scan_ch_o    = scan_ch_r;
  assign scan_last_o  = scan_last_r;
  assign scan_data_o  = scan_valid_r ? mem_rdata_s : {DATA_W{1'b0}};
  // Busy is low while reset is held so every output reads 0 in reset
  assign busy_o       = rst_n_i && (state_r != ST_IDLE);

endmodule

// File: doc/psg_attr_ram.md
# psg_attr_ram

Parametrised per-channel attribute store for the PSG audio engine. The CPU writes channel attributes one byte at a time. The memory returns full channel words in two ways: a one-cycle random read, and an autonomous channel scan that the PSG sequencer triggers once per sample period. After reset, and on request, a built-in clear sequencer zeroes the whole memory.

## Interface
Parameters:
- NUM_CH, default 16: number of channels (words); 2 to 64.
- BYTES_PER_CH, default 4: bytes per channel word; must be a power of two, 1 to 8.
- Derived localparams: CH_W = $clog2(NUM_CH), LANE_W = $clog2(BYTES_PER_CH), ADDR_W = CH_W + LANE_W, DATA_W = 8*BYTES_PER_CH.

Ports:
- clk_i  in  1  single clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- clear_i  in  1  pulse that restarts the clear sequence.
- wr_en_i  in  1  byte write strobe.
- wr_addr_i  in  ADDR_W  byte address: {channel, lane}.
- wr_data_i  in  8  write byte.
- rd_en_i  in  1  random read request.
- rd_addr_i  in  CH_W  channel to read.
- rd_data_o  out  DATA_W  random read data.
- rd_valid_o  out  1  rd_data_o is valid this cycle.
- scan_start_i  in  1  pulse that starts a channel scan.
- scan_valid_o  out  1  scan output beat is valid.
- scan_ch_o  out  CH_W  channel index of the beat.
- scan_data_o  out  DATA_W  channel word of the beat.
- scan_last_o  out  1  beat is channel NUM_CH-1.
- busy_o  out  1  state is not IDLE.

## Operation
- Storage is NUM_CH x DATA_W, with one write port (byte-lane enables) and one registered read port.
- FSM states: CLEAR, IDLE, SCAN.
  - While rst_n_i is low, the state is CLEAR with the clear counter at 0.
  - CLEAR writes zero to word clr_cnt each cycle. clr_cnt counts 0 to NUM_CH-1, then the state goes to IDLE.
  - In IDLE, scan_start_i moves the state to SCAN with scan_cnt = 0.
  - SCAN issues a read of scan_cnt each cycle that is not stalled. After issuing NUM_CH-1, the state goes to IDLE.
  - clear_i in any state forces CLEAR with clr_cnt = 0. An in-flight scan is abandoned: no further scan beats are issued, and a beat already issued is suppressed.
- CPU write: lane wr_addr_i[LANE_W-1:0] of word wr_addr_i[ADDR_W-1:LANE_W] receives wr_data_i.
  - Writes to a channel index >= NUM_CH are dropped.
  - Writes arriving while in CLEAR are dropped.
- Read port arbitration:
  - CLEAR never reads.
  - Otherwise, rd_en_i has priority. A random read wins the cycle, and scan_cnt holds (a scan stall).
  - rd_en_i while in CLEAR is ignored; rd_valid_o stays 0.
  - rd_addr_i >= NUM_CH returns 0 with rd_valid_o = 1.
- Same-cycle write and read to the same word return the pre-write value (read-before-write).
- scan_start_i is ignored in CLEAR and in SCAN; there is no restart and no queueing.

## Timing
- Every output resets to 0. The first cycle after rst_n_i rises is CLEAR with clr_cnt = 0, and busy_o = 1.
- Clear takes exactly NUM_CH cycles. IDLE is reached on cycle NUM_CH after reset release.
- Random read: rd_en_i sampled at cycle N gives rd_data_o and rd_valid_o = 1 at N+1.
  - rd_data_o holds its value until the next read; rd_valid_o lasts one cycle.
- Scan:
  - scan_start_i at cycle N enters SCAN at N+1 and issues channel 0.
  - Beat k appears one cycle after its issue, with scan_ch_o = k.
  - With no stalls, beats appear at N+2 through N+1+NUM_CH, and scan_last_o coincides with the beat for channel NUM_CH-1.
  - Each stall delays all remaining beats by one cycle.
- busy_o drops the cycle the FSM leaves SCAN, which is the cycle the last beat is output.
- scan_valid_o and rd_valid_o may be high in different cycles only, never together, because the read port is shared.

## Structure
- A shared audio package holds the FSM state enum (CLEAR, IDLE, SCAN) and the parameter legality checks (power-of-two BYTES_PER_CH, NUM_CH range), asserted at elaboration.
- One sub-module, psg_attr_mem: a NUM_CH x DATA_W array with byte-lane write and registered read. It contains no reset logic, so it infers block RAM.
- The FSM, counters and arbitration live in the top module.

## Test plan
1. Reset release, NUM_CH = 16: busy_o = 1 for 16 cycles, then 0. A scan afterwards returns 16 beats of 0x00000000, scan_ch_o = 0 to 15, and scan_last_o only on beat 15.
2. Write bytes 0x11, 0x22, 0x33, 0x44 to addresses 20 to 23, then random read channel 5: rd_data_o = 0x44332211 one cycle after rd_en_i, with rd_valid_o pulsed once.
3. Scan with rd_en_i asserted on the cycles of beats 3 and 4: scan_cnt holds, beats are still contiguous in channel order, 18 cycles total, and each random read returns the correct word.
4. Same-cycle write 0xAA to byte 8 and random read of channel 2 (old value 0): rd_data_o = 0. A second read returns 0x000000AA.
5. clear_i pulsed mid-scan at beat 7: no beats after the suppressed one, busy_o high for 16 more cycles, and a write issued during CLEAR is lost (a later read gives 0).
6. NUM_CH = 12, BYTES_PER_CH = 8: a write to channel 13 is dropped, and a read of channel 13 returns 0 with rd_valid_o = 1.
